param_proc_core: RTL and testbench

PARAM_PROC_CORE -- requirements
Module: param_proc_core

---
 rtl/param_proc_core.sv | 159 +++++++++++++++
 tb/tb_param_proc_core.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_proc_core.sv
// param_proc_core: accumulator core with register file, flags and optional shift-add MUL (macro PARAM_PROC_MUL_EN).
// One instruction per cycle while in_ready; MUL drops in_ready for DATA_W cycles, HLT drops it until rst.
module param_proc_core #(
  parameter int DATA_W = 8,
  parameter int NREG   = 8,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [AW-1:0]     ra,
  input  logic [AW-1:0]     rb,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] acc,
  output logic [3:0]        flags,
  output logic              halted,
  output logic [DATA_W-1:0] dbg_rdata
);
  localparam logic [3:0] OP_ROT  = 4'h0;
  localparam logic [3:0] OP_MOVA = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_INR  = 4'h5;
  localparam logic [3:0] OP_DCR  = 4'h6;
  localparam logic [3:0] OP_ADI  = 4'h7;
  localparam logic [3:0] OP_HLT  = 4'h8;
  localparam logic [3:0] OP_SBI  = 4'h9;
  localparam logic [3:0] OP_NOP  = 4'hA;
  localparam logic [3:0] OP_MOV  = 4'hB;
  localparam logic [3:0] OP_MVI  = 4'hC;
  localparam logic [3:0] OP_ORI  = 4'hD;
  localparam logic [3:0] OP_ANI  = 4'hE;
  localparam logic [3:0] OP_XRI  = 4'hF;

`ifdef PARAM_PROC_MUL_EN
  localparam logic [3:0] OP_MUL = 4'h4;
  typedef enum logic [1:0] {S_RUN, S_MUL, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_RUN, S_HALT} state_t;
`endif

  state_t            state;
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] a_val, b_val, res;
  logic [DATA_W:0]   wide;
  logic              c_new, arith, set_acc, set_flags, reg_we;

  assign a_val     = regs[ra];
  assign b_val     = regs[rb];
  assign dbg_rdata = a_val;
  assign in_ready  = (state == S_RUN);
  assign halted    = (state == S_HALT);

  always_comb begin
    res       = acc;
    c_new     = flags[1];
    wide      = '0;
    arith     = 1'b0;
    set_acc   = 1'b0;
    set_flags = 1'b0;
    reg_we    = 1'b0;
    case (op)
      OP_ROT: begin
        set_acc   = 1'b1;
        set_flags = 1'b1;
        if (ra[0]) begin
          res   = {acc[0], acc[DATA_W-1:1]};
          c_new = acc[0];
        end else begin
          res   = {acc[DATA_W-2:0], acc[DATA_W-1]};
          c_new = acc[DATA_W-1];
        end
      end
      OP_MOVA: begin set_acc = 1'b1; res = b_val; end
      // the extra top bit of wide is carry for adds and borrow for subtracts
      OP_ADD: begin arith = 1'b1; wide = {1'b0, a_val} + {1'b0, b_val}; end
      OP_SUB: begin arith = 1'b1; wide = {1'b0, a_val} - {1'b0, b_val}; end
      OP_ADI: begin arith = 1'b1; wide = {1'b0, a_val} + {1'b0, imm}; end
      OP_SBI: begin arith = 1'b1; wide = {1'b0, a_val} - {1'b0, imm}; end
      OP_INR: begin reg_we = 1'b1; set_flags = 1'b1; res = a_val + DATA_W'(1); end
      OP_DCR: begin reg_we = 1'b1; set_flags = 1'b1; res = a_val - DATA_W'(1); end
      OP_MOV: begin reg_we = 1'b1; res = b_val; end
      OP_MVI: begin reg_we = 1'b1; res = imm; end
      OP_ORI: begin set_acc = 1'b1; set_flags = 1'b1; c_new = 1'b0; res = acc | imm; end
      OP_ANI: begin set_acc = 1'b1; set_flags = 1'b1; c_new = 1'b0; res = acc & imm; end
      OP_XRI: begin set_acc = 1'b1; set_flags = 1'b1; c_new = 1'b0; res = acc ^ imm; end
      OP_NOP: ;
      default: ;
    endcase
    if (arith) begin
      set_acc   = 1'b1;
      set_flags = 1'b1;
      res       = wide[DATA_W-1:0];
      c_new     = wide[DATA_W];
    end
  end

`ifdef PARAM_PROC_MUL_EN
  localparam int            CW       = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);
  localparam logic [AW-1:0] R_HI     = AW'(NREG - 2);
  localparam logic [AW-1:0] R_LO     = AW'(NREG - 1);

  logic [2*DATA_W-1:0] mcand, prod, prod_nxt;
  logic [DATA_W-1:0]   mplier;
  logic [CW-1:0]       cnt;

  assign prod_nxt = mplier[0] ? prod + mcand : prod;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
      acc   <= '0;
      flags <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
`ifdef PARAM_PROC_MUL_EN
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
      cnt    <= '0;
`endif
    end else begin
      case (state)
        S_RUN: if (in_valid) begin
          if (set_acc)   acc <= res;
          if (set_flags) flags <= {res[DATA_W-1], res == '0, c_new, ~^res};
          if (reg_we)    regs[ra] <= res;
          if (op == OP_HLT) state <= S_HALT;
`ifdef PARAM_PROC_MUL_EN
          if (op == OP_MUL) begin
            state  <= S_MUL;
            mcand  <= {{DATA_W{1'b0}}, a_val};
            mplier <= b_val;
            prod   <= '0;
            cnt    <= '0;
          end
`endif
        end
`ifdef PARAM_PROC_MUL_EN
        S_MUL: begin
          prod   <= prod_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            regs[R_HI] <= prod_nxt[2*DATA_W-1:DATA_W];
            regs[R_LO] <= prod_nxt[DATA_W-1:0];
            state      <= S_RUN;
          end
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_param_proc_core.sv
// Bench for param_proc_core: directed vector table, corner sequences, randomized run against a reference model.
module tb_param_proc_core;
  localparam int W = 8;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, halted;
  logic [3:0] op, flags;
  logic [2:0] ra, rb;
  logic [7:0] imm, acc, dbg_rdata;

  always #5 clk = ~clk;

  param_proc_core #(.DATA_W(W), .NREG(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .ra(ra), .rb(rb), .imm(imm), .acc(acc), .flags(flags),
    .halted(halted), .dbg_rdata(dbg_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned m_reg [N];
  int unsigned m_acc;
  bit ms, mz, mc, mp;

  typedef struct {
    logic [3:0] op;
    logic [2:0] ra, rb;
    logic [7:0] imm;
    logic [7:0] acc;
    logic [3:0] flags;
    logic [7:0] dbg;
  } vec_t;
  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_reg[k] = 0;
    m_acc = 0; ms = 0; mz = 0; mc = 0; mp = 0;
  endtask

  // Reference behaviour from the instruction definitions, using plain integer arithmetic.
  task automatic model_exec(input int o, input int a, input int b, input int i);
    int unsigned x, y, r;
    bit alu;
    x = m_reg[a]; y = m_reg[b]; r = 0; alu = 0;
    case (o)
      0: begin
        alu = 1;
        if (a % 2 == 0) begin mc = (m_acc >= 128); r = (m_acc * 2) % 256 + (mc ? 1 : 0); end
        else begin mc = (m_acc % 2 == 1); r = m_acc / 2 + (mc ? 128 : 0); end
        m_acc = r;
      end
      1: m_acc = y;
      2: begin alu = 1; r = x + y; mc = (r > 255); r = r % 256; m_acc = r; end
      3: begin alu = 1; mc = (y > x); r = (x + 256 - y) % 256; m_acc = r; end
      7: begin alu = 1; r = x + i; mc = (r > 255); r = r % 256; m_acc = r; end
      9: begin alu = 1; mc = (i > x); r = (x + 256 - i) % 256; m_acc = r; end
      5: begin alu = 1; r = (x + 1) % 256; m_reg[a] = r; end
      6: begin alu = 1; r = (x + 255) % 256; m_reg[a] = r; end
      11: m_reg[a] = y;
      12: m_reg[a] = i;
      13: begin alu = 1; mc = 0; r = m_acc | i; m_acc = r; end
      14: begin alu = 1; mc = 0; r = m_acc & i; m_acc = r; end
      15: begin alu = 1; mc = 0; r = m_acc ^ i; m_acc = r; end
`ifdef PARAM_PROC_MUL_EN
      4: begin r = x * y; m_reg[N-2] = r / 256; m_reg[N-1] = r % 256; end
`endif
      default: ;
    endcase
    if (alu) begin ms = (r >= 128); mz = (r == 0); mp = ($countones(r) % 2 == 0); end
  endtask

  // Called at a negedge with in_ready high; returns at the negedge after the accepting edge.
  task automatic send(input logic [3:0] o, input logic [2:0] a, input logic [2:0] b, input logic [7:0] i);
    op = o; ra = a; rb = b; imm = i; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic read_reg(input int idx, output logic [7:0] v);
    ra = 3'(idx);
    #1;
    v = dbg_rdata;
  endtask

  task automatic sweep(input string tag);
    logic [7:0] v;
    for (int k = 0; k < N; k++) begin
      read_reg(k, v);
      check($sformatf("%s_r%0d", tag, k), v, m_reg[k]);
    end
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] v;
    rst = 1'b1; in_valid = 1'b0; op = '0; ra = '0; rb = '0; imm = '0;

    //             op     ra    rb    imm    acc    flags    dbg
    vecs[0]  = '{4'hC, 3'd1, 3'd0, 8'hFF, 8'h00, 4'b0000, 8'hFF};
    vecs[1]  = '{4'hC, 3'd2, 3'd0, 8'h01, 8'h00, 4'b0000, 8'h01};
    vecs[2]  = '{4'h2, 3'd1, 3'd2, 8'h00, 8'h00, 4'b0111, 8'hFF};
    vecs[3]  = '{4'hC, 3'd3, 3'd0, 8'h05, 8'h00, 4'b0111, 8'h05};
    vecs[4]  = '{4'hC, 3'd4, 3'd0, 8'h07, 8'h00, 4'b0111, 8'h07};
    vecs[5]  = '{4'h3, 3'd3, 3'd4, 8'h00, 8'hFE, 4'b1010, 8'h05};
    vecs[6]  = '{4'hE, 3'd0, 3'd0, 8'h00, 8'h00, 4'b0101, 8'h00};
    vecs[7]  = '{4'hD, 3'd0, 3'd0, 8'h81, 8'h81, 4'b1001, 8'h00};
    vecs[8]  = '{4'h0, 3'd0, 3'd0, 8'h00, 8'h03, 4'b0011, 8'h00};
    vecs[9]  = '{4'h0, 3'd1, 3'd0, 8'h00, 8'h81, 4'b1011, 8'hFF};
    vecs[10] = '{4'h5, 3'd1, 3'd0, 8'h00, 8'h81, 4'b0111, 8'h00};
    vecs[11] = '{4'h6, 3'd1, 3'd0, 8'h00, 8'h81, 4'b1011, 8'hFF};
    vecs[12] = '{4'hB, 3'd5, 3'd3, 8'h00, 8'h81, 4'b1011, 8'h05};
    vecs[13] = '{4'h1, 3'd5, 3'd4, 8'h00, 8'h07, 4'b1011, 8'h05};
    vecs[14] = '{4'h7, 3'd2, 3'd0, 8'hFE, 8'hFF, 4'b1001, 8'h01};
    vecs[15] = '{4'h9, 3'd2, 3'd0, 8'h01, 8'h00, 4'b0101, 8'h01};
    vecs[16] = '{4'hF, 3'd0, 3'd0, 8'h3C, 8'h3C, 4'b0001, 8'h00};
    vecs[17] = '{4'hA, 3'd0, 3'd0, 8'h00, 8'h3C, 4'b0001, 8'h00};
    vecs[18] = '{4'h9, 3'd0, 3'd0, 8'h01, 8'hFF, 4'b1011, 8'h00};
    vecs[19] = '{4'h2, 3'd1, 3'd1, 8'h00, 8'hFE, 4'b1010, 8'hFF};

    // Reset state
    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_halted", halted, 0);
    check("rst_acc", acc, 0);
    check("rst_flags", flags, 0);
    sweep("rst");

    // Directed vector table
    for (int k = 0; k < 20; k++) begin
      send(vecs[k].op, vecs[k].ra, vecs[k].rb, vecs[k].imm);
      check($sformatf("vec%0d_acc", k), acc, vecs[k].acc);
      check($sformatf("vec%0d_flags", k), flags, vecs[k].flags);
      check($sformatf("vec%0d_dbg", k), dbg_rdata, vecs[k].dbg);
      check($sformatf("vec%0d_ready", k), in_ready, 1);
    end

    // HLT freezes everything and ignores offered instructions until reset
    do_reset();
    send(4'hC, 3'd0, 3'd0, 8'h12);
    send(4'hD, 3'd0, 3'd0, 8'h5A);
    send(4'h8, 3'd0, 3'd0, 8'h00);
    check("hlt_halted", halted, 1);
    check("hlt_ready", in_ready, 0);
    op = 4'hC; ra = 3'd0; imm = 8'h55; in_valid = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    read_reg(0, v);
    check("hlt_r0_frozen", v, 8'h12);
    check("hlt_acc_frozen", acc, 8'h5A);
    check("hlt_flags_frozen", flags, 4'b0001);
    check("hlt_still_halted", halted, 1);
    do_reset();
    check("hlt_rst_ready", in_ready, 1);
    check("hlt_rst_halted", halted, 0);
    read_reg(0, v);
    check("hlt_rst_r0", v, 8'h00);
    @(negedge clk);

`ifdef PARAM_PROC_MUL_EN
    // MUL timing, result placement, flags untouched, busy-cycle offers ignored
    do_reset();
    send(4'hC, 3'd6, 3'd0, 8'h0F);
    send(4'hC, 3'd7, 3'd0, 8'h11);
    send(4'hD, 3'd0, 3'd0, 8'h81);
    send(4'h4, 3'd6, 3'd7, 8'h00);
    op = 4'hC; ra = 3'd0; imm = 8'h55; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    wait_ready(n);
    check("mul_busy_cycles", n + 3, W);
    read_reg(6, v); check("mul_r6", v, 8'h00);
    read_reg(7, v); check("mul_r7", v, 8'hFF);
    read_reg(0, v); check("mul_r0_ignored", v, 8'h00);
    check("mul_flags_kept", flags, 4'b1001);
    check("mul_acc_kept", acc, 8'h81);
    @(negedge clk);
    // Operands aliasing the result registers use values captured at acceptance
    send(4'h4, 3'd7, 3'd7, 8'h00);
    wait_ready(n);
    check("mul_alias_busy", n, W);
    read_reg(6, v); check("mul_alias_r6", v, 8'hFE);
    read_reg(7, v); check("mul_alias_r7", v, 8'h01);
    @(negedge clk);

    // Reset on the 4th MUL cycle discards the multiply
    do_reset();
    send(4'hC, 3'd6, 3'd0, 8'h0F);
    send(4'hC, 3'd7, 3'd0, 8'h11);
    send(4'hD, 3'd0, 3'd0, 8'h01);
    send(4'h4, 3'd6, 3'd7, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("mulrst_ready", in_ready, 1);
    check("mulrst_acc", acc, 0);
    check("mulrst_flags", flags, 0);
    repeat (12) @(negedge clk);
    read_reg(6, v); check("mulrst_r6", v, 8'h00);
    read_reg(7, v); check("mulrst_r7", v, 8'h00);
    @(negedge clk);
`else
    // Opcode 0100 behaves as a single-cycle NOP
    do_reset();
    send(4'hC, 3'd6, 3'd0, 8'h0F);
    send(4'hC, 3'd7, 3'd0, 8'h11);
    send(4'hD, 3'd0, 3'd0, 8'h81);
    send(4'h4, 3'd6, 3'd7, 8'h00);
    check("mulnop_ready", in_ready, 1);
    check("mulnop_acc", acc, 8'h81);
    check("mulnop_flags", flags, 4'b1001);
    read_reg(6, v); check("mulnop_r6", v, 8'h0F);
    read_reg(7, v); check("mulnop_r7", v, 8'h11);
    @(negedge clk);
`endif

    // Randomized instruction stream against the reference model
    do_reset();
    for (int t = 0; t < 400; t++) begin
      int o, a, b, i;
      o = $urandom_range(0, 15);
      if (o == 8) o = 10;
      a = $urandom_range(0, 7);
      b = $urandom_range(0, 7);
      i = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 255);
      send(4'(o), 3'(a), 3'(b), 8'(i));
      model_exec(o, a, b, i);
`ifdef PARAM_PROC_MUL_EN
      if (o == 4) begin
        wait_ready(n);
        check($sformatf("rnd%0d_mul_busy", t), n, W);
      end
`endif
      check($sformatf("rnd%0d_acc", t), acc, m_acc);
      check($sformatf("rnd%0d_flags", t), flags, {ms, mz, mc, mp});
      check($sformatf("rnd%0d_dbg", t), dbg_rdata, m_reg[a]);
      check($sformatf("rnd%0d_ready", t), in_ready, 1);
      if (t % 40 == 39) sweep($sformatf("rnd%0d", t));
    end
    sweep("rnd_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
